// File: rtl/imem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_ctrl
// Brief    : Instruction memory controller with valid/ready fetch and response
//            handshakes, fault flagging, redirect flush and configurable read
//            latency. Optional load port enabled by IMEM_LOAD_PORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_ctrl #(
    parameter int          DEPTH_WORDS = 32768,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
    parameter string       INIT_FILE   = "program.hex"
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef IMEM_LOAD_PORT_EN
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data,
    input  logic [3:0]                     ld_be,
`endif
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    input  logic                           flush,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_data,
    output logic                           resp_fault,
    output logic                           busy
);

    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam int          c_CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_AW-1:0] r_idx;
    logic            r_req_fault;
    logic            r_resp_fault;
    logic            r_nop;
    logic [31:0]     r_rd_data;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic [31:0]     w_offset;
    logic [c_AW-1:0] w_req_idx;
    logic            w_req_fault;
    logic            w_accept;
    logic            w_ld_busy;
    logic            w_rd_fire;
    logic            w_rd_fault;
    logic [c_AW-1:0] w_rd_idx;

    // Below-base addresses wrap to a huge offset, so one compare covers both ends.
    assign w_offset    = req_addr - BASE_ADDR;
    assign w_req_idx   = c_AW'(w_offset >> 2);
    assign w_req_fault = (req_addr[1:0] != 2'b00) || ({1'b0, w_offset} >= c_SPAN);
    assign w_accept    = req_valid && req_ready;

`ifdef IMEM_LOAD_PORT_EN
    assign w_ld_busy = ld_en;
`else
    assign w_ld_busy = 1'b0;
`endif

    // Single-cycle fetches read at the accepting edge; longer ones read on the last WAIT cycle.
    assign w_rd_fire  = (LATENCY == 1) ? w_accept
                                       : ((r_state == S_WAIT) && (r_cnt == c_CW'(1)) && !flush);
    assign w_rd_fault = (LATENCY == 1) ? w_req_fault : r_req_fault;
    assign w_rd_idx   = (LATENCY == 1) ? w_req_idx : r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == c_CW'(1)) w_next_state = S_RESP;
                end
                S_RESP: begin
                    if (w_accept)        w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                    else if (resp_ready) w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = !flush && !w_ld_busy &&
                     ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
        resp_valid = (r_state == S_RESP);
        busy       = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_cnt        <= '0;
            r_req_fault  <= 1'b0;
            r_resp_fault <= 1'b0;
            r_nop        <= 1'b1;
        end else begin
            if (w_accept) begin
                r_cnt       <= c_CW'(LATENCY - 1);
                r_req_fault <= w_req_fault;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
            if (w_rd_fire) begin
                r_nop        <= w_rd_fault;
                r_resp_fault <= w_rd_fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_idx <= w_req_idx;
    end

    // Kept free of reset so the array and its output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_rd_fire && !w_rd_fault) r_rd_data <= r_mem[w_rd_idx];
    end

`ifdef IMEM_LOAD_PORT_EN
    always_ff @(posedge clk) begin
        if (rst_n && ld_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be[b]) r_mem[ld_addr][8*b +: 8] <= ld_data[8*b +: 8];
            end
        end
    end
`endif

    assign resp_data  = r_nop ? NOP_WORD : r_rd_data;
    assign resp_fault = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_ctrl
// Brief    : Self-checking bench for imem_ctrl with LATENCY 1, 3 and 4 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_ctrl;

   localparam int          N     = 3;
   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_0400;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   function automatic logic [31:0] golden(input int i);
      return (i == 0) ? 32'h0050_0093 : ((32'h9E37_79B9 * i) ^ 32'h0000_5A5A);
   endfunction

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid  [N];
   logic        req_ready  [N];
   logic [31:0] req_addr   [N];
   logic        flush      [N];
   logic        resp_valid [N];
   logic        resp_ready [N];
   logic [31:0] resp_data  [N];
   logic        resp_fault [N];
   logic        busy       [N];
`ifdef IMEM_LOAD_PORT_EN
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  ld_be;
`endif

   logic [31:0] model_mem [DEPTH];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      imem_ctrl #(
         .DEPTH_WORDS(DEPTH),
         .BASE_ADDR  (BASE),
         .LATENCY    (lat_of(g)),
         .NOP_WORD   (NOP),
         .INIT_FILE  ("")
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
`ifdef IMEM_LOAD_PORT_EN
         .ld_en     (ld_en),
         .ld_addr   (ld_addr),
         .ld_data   (ld_data),
         .ld_be     (ld_be),
`endif
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .flush     (flush[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_data (resp_data[g]),
         .resp_fault(resp_fault[g]),
         .busy      (busy[g])
      );
      initial begin
         for (int i = 0; i < DEPTH; i++) u_dut.r_mem[i] = golden(i);
      end
   end

   function automatic logic ref_fault(input logic [31:0] addr);
      longint a;
      a = longint'({32'd0, addr});
      return (addr[1:0] != 2'b00) || (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 4);
   endfunction

   function automatic logic [31:0] ref_data(input logic [31:0] addr);
      if (ref_fault(addr)) return NOP;
      return model_mem[(addr - BASE) / 4];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         req_valid[k]  = 1'b0;
         req_addr[k]   = 32'h0;
         flush[k]      = 1'b0;
         resp_ready[k] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_all();
      repeat (3) step();
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         checks++;
         if (resp_valid[k] !== 1'b0 || resp_data[k] !== NOP || resp_fault[k] !== 1'b0 ||
             busy[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL reset_state k=%0d got v=%b d=%h f=%b busy=%b rdy=%b want v=0 d=%h f=0 busy=0 rdy=1",
                     k, resp_valid[k], resp_data[k], resp_fault[k], busy[k], req_ready[k], NOP);
         end
      end
      step();
      rst_n = 1'b1;
      step();
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE;
      step();
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h0050_0093 || resp_fault[0] !== 1'b0) begin
         errors++;
         $display("FAIL first_fetch got v=%b d=%h f=%b want v=1 d=00500093 f=0",
                  resp_valid[0], resp_data[0], resp_fault[0]);
      end
      step();
      resp_ready[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b0 || resp_data[0] !== 32'h0050_0093 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL after_consume got v=%b d=%h busy=%b want v=0 d=00500093 busy=0",
                  resp_valid[0], resp_data[0], busy[0]);
      end
      step();
   endtask

   task automatic test_back_to_back();
      resp_ready[0] = 1'b1;
      for (int j = 0; j < 5; j++) begin
         req_valid[0] = (j < 3);
         req_addr[0]  = BASE + 32'(4 * j);
         @(negedge clk);
         if (j < 3) begin
            checks++;
            if (req_ready[0] !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready j=%0d got %b want 1", j, req_ready[0]);
            end
         end
         if (j >= 1 && j <= 3) begin
            checks++;
            if (resp_valid[0] !== 1'b1 || resp_data[0] !== golden(j - 1)) begin
               errors++;
               $display("FAIL b2b_resp j=%0d got v=%b d=%h want v=1 d=%h",
                        j, resp_valid[0], resp_data[0], golden(j - 1));
            end
         end
         if (j == 4) begin
            checks++;
            if (resp_valid[0] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_end got v=%b want 0", resp_valid[0]);
            end
         end
         step();
      end
      idle_all();
   endtask

   task automatic test_latency_hold();
      req_valid[1] = 1'b1;
      req_addr[1]  = BASE + 32'd28;
      step();
      req_valid[1] = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         resp_ready[1] = (c == 7);
         @(negedge clk);
         checks++;
         if (c < 3) begin
            if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
               errors++;
               $display("FAIL lat3_wait c=%0d got v=%b busy=%b rdy=%b want v=0 busy=1 rdy=0",
                        c, resp_valid[1], busy[1], req_ready[1]);
            end
         end else if (c < 8) begin
            if (resp_valid[1] !== 1'b1 || resp_data[1] !== golden(7) ||
                req_ready[1] !== (c == 7)) begin
               errors++;
               $display("FAIL lat3_hold c=%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=%b",
                        c, resp_valid[1], resp_data[1], req_ready[1], golden(7), (c == 7));
            end
         end else begin
            if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
               errors++;
               $display("FAIL lat3_idle got v=%b busy=%b want v=0 busy=0", resp_valid[1], busy[1]);
            end
         end
         step();
      end
      idle_all();
   endtask

   task automatic test_fault();
      logic [31:0] addrs [4];
      addrs[0] = BASE + 32'd2;
      addrs[1] = BASE + 32'(DEPTH * 4);
      addrs[2] = BASE - 32'd4;
      addrs[3] = BASE + 32'(DEPTH * 4 - 4);
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 4; a++) begin
            req_valid[k]  = 1'b1;
            req_addr[k]   = addrs[a];
            resp_ready[k] = 1'b1;
            step();
            req_valid[k] = 1'b0;
            for (int c = 1; c <= lat_of(k); c++) begin
               @(negedge clk);
               checks++;
               if (c < lat_of(k)) begin
                  if (resp_valid[k] !== 1'b0) begin
                     errors++;
                     $display("FAIL fault_early k=%0d a=%h c=%0d got v=%b want 0", k, addrs[a], c, resp_valid[k]);
                  end
               end else if (resp_valid[k] !== 1'b1 || resp_fault[k] !== (a != 3) ||
                            resp_data[k] !== ((a != 3) ? NOP : golden(DEPTH - 1))) begin
                  errors++;
                  $display("FAIL fault_resp k=%0d a=%h got v=%b f=%b d=%h want v=1 f=%b d=%h",
                           k, addrs[a], resp_valid[k], resp_fault[k], resp_data[k], (a != 3),
                           (a != 3) ? NOP : golden(DEPTH - 1));
               end
               step();
            end
         end
         idle_all();
         step();
      end
   endtask

   task automatic test_flush();
      req_valid[2] = 1'b1;
      req_addr[2]  = BASE + 32'd12;
      step();
      req_valid[2] = 1'b0;
      step();
      flush[2]     = 1'b1;
      req_valid[2] = 1'b1;
      req_addr[2]  = BASE + 32'd16;
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready got %b want 0", req_ready[2]);
      end
      step();
      flush[2]     = 1'b0;
      req_valid[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b1 || busy[2] !== 1'b0 || resp_data[2] !== NOP || resp_fault[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_after got rdy=%b busy=%b d=%h f=%b want rdy=1 busy=0 d=%h f=0",
                  req_ready[2], busy[2], resp_data[2], resp_fault[2], NOP);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (resp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL flush_killed c=%0d got v=%b want 0", c, resp_valid[2]);
         end
         step();
      end
   endtask

   task automatic test_reset_in_resp();
      req_valid[1] = 1'b1;
      req_addr[1]  = BASE + 32'd40;
      step();
      req_valid[1] = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid[1] !== 1'b0 || resp_data[1] !== NOP || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_resp got v=%b d=%h busy=%b want v=0 d=%h busy=0",
                  resp_valid[1], resp_data[1], busy[1], NOP);
      end
      step();
   endtask

`ifdef IMEM_LOAD_PORT_EN
   task automatic test_load();
      logic [31:0] want;
      ld_en   = 1'b1;
      ld_addr = 6'd5;
      ld_data = 32'hDEAD_BEEF;
      ld_be   = 4'b0011;
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE + 32'h14;
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL load_stall got %b want 0", req_ready[0]);
      end
      step();
      ld_en = 1'b0;
      model_mem[5][15:0] = 16'hBEEF;
      want = model_mem[5];
      step();
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== want) begin
         errors++;
         $display("FAIL load_fetch got v=%b d=%h want v=1 d=%h", resp_valid[0], resp_data[0], want);
      end
      step();
      idle_all();
   endtask
`endif

   task automatic test_random(input int k);
      bit          pend = 1'b0;
      int          left = 0;
      logic [31:0] mdata = NOP;
      logic        mfault = 1'b0;
      logic        exp_valid;
      logic        exp_ready;
      int          r;
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 7));
         req_valid[k]  = ($urandom_range(0, 2) != 0);
         resp_ready[k] = ($urandom_range(0, 3) != 0);
         flush[k]      = ($urandom_range(0, 19) == 0);
         if (r < 5)       req_addr[k] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         else if (r == 5) req_addr[k] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
         else if (r == 6) req_addr[k] = BASE - 32'(4 * $urandom_range(1, 16));
         else             req_addr[k] = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
         exp_valid = pend && (left == 0);
         exp_ready = !flush[k] && (!pend || (exp_valid && resp_ready[k]));
         @(negedge clk);
         checks++;
         if (resp_valid[k] !== exp_valid || req_ready[k] !== exp_ready || busy[k] !== pend) begin
            errors++;
            $display("FAIL rand_ctrl k=%0d n=%0d got v=%b rdy=%b busy=%b want v=%b rdy=%b busy=%b",
                     k, n, resp_valid[k], req_ready[k], busy[k], exp_valid, exp_ready, pend);
         end
         if (exp_valid) begin
            checks++;
            if (resp_data[k] !== mdata || resp_fault[k] !== mfault) begin
               errors++;
               $display("FAIL rand_data k=%0d n=%0d got d=%h f=%b want d=%h f=%b",
                        k, n, resp_data[k], resp_fault[k], mdata, mfault);
            end
         end
         if (flush[k]) begin
            pend = 1'b0;
         end else begin
            if (exp_valid && resp_ready[k]) pend = 1'b0;
            else if (pend && left > 0)      left--;
            if (req_valid[k] && exp_ready) begin
               pend   = 1'b1;
               left   = lat_of(k) - 1;
               mfault = ref_fault(req_addr[k]);
               mdata  = ref_data(req_addr[k]);
            end
         end
         step();
      end
      idle_all();
      flush[k] = 1'b1;
      step();
      flush[k] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = golden(i);
`ifdef IMEM_LOAD_PORT_EN
      ld_en   = 1'b0;
      ld_addr = 6'd0;
      ld_data = 32'h0;
      ld_be   = 4'h0;
`endif
      test_reset();
      test_back_to_back();
      test_latency_hold();
      test_fault();
      test_flush();
      test_reset_in_resp();
`ifdef IMEM_LOAD_PORT_EN
      test_load();
`endif
      for (int k = 0; k < N; k++) test_random(k);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
